// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register of the RV32I core.
// Owns the program counter, presents the fetch address to instruction memory and
// registers the fetched word into decode. It also applies load-use stalls,
// branch/jump redirects and the terminal halt requested by decode.
//
// Ports:
//   clk          core clock, rising edge
//   reset        synchronous active-high reset
//   Stall        load-use stall: hold PC and IF/ID
//   Flush        taken branch/JAL/JALR in EX: redirect to BranchTarget, squash IF/ID
//   BranchTarget redirect address (bits [1:0] forced to 0)
//   HaltD        halt decode of the instruction in IF/ID
//   InstrAddr    fetch address, mirrors the PC register
//   InstrData    instruction word read combinationally at InstrAddr
//   D_PC         PC of the instruction in IF/ID
//   D_PCFour     D_PC + 4 (link value)
//   D_Instr      instruction in IF/ID
//   D_Valid      IF/ID holds a real instruction
//   Halted       core halted, sticky until reset
//   FetchCount   number of valid instructions loaded into IF/ID (wraps)
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic [31:0] BranchTarget,
    input  logic        HaltD,
    output logic [31:0] InstrAddr,
    input  logic [31:0] InstrData,
    output logic [31:0] D_PC,
    output logic [31:0] D_PCFour,
    output logic [31:0] D_Instr,
    output logic        D_Valid,
    output logic        Halted,
    output logic [31:0] FetchCount
);

    localparam logic StRun    = 1'b0;
    localparam logic StHalted = 1'b1;

    logic        state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] d_pc_q, d_pc_d;
    logic [31:0] d_pc_four_q, d_pc_four_d;
    logic [31:0] d_instr_q, d_instr_d;
    logic        d_valid_q, d_valid_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] pc_plus_four;
    logic        halt_entry;

    assign pc_plus_four = pc_q + 32'd4;
    // A HALT in ID is younger than a branch resolving in EX, so Flush squashes it.
    assign halt_entry   = HaltD && d_valid_q && !Flush;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        d_pc_d        = d_pc_q;
        d_pc_four_d   = d_pc_four_q;
        d_instr_d     = d_instr_q;
        d_valid_d     = d_valid_q;
        fetch_count_d = fetch_count_q;

        if (state_q == StHalted) begin
            // Terminal: PC frozen, bubbles into decode, Stall/Flush ignored.
            d_instr_d = NOP_INSTR;
            d_valid_d = 1'b0;
        end else if (Flush) begin
            pc_d      = {BranchTarget[31:2], 2'b00};
            d_instr_d = NOP_INSTR;
            d_valid_d = 1'b0;
        end else if (halt_entry) begin
            state_d   = StHalted;
            d_instr_d = NOP_INSTR;
            d_valid_d = 1'b0;
        end else if (!Stall) begin
            pc_d          = pc_plus_four;
            d_pc_d        = pc_q;
            d_pc_four_d   = pc_plus_four;
            d_instr_d     = InstrData;
            d_valid_d     = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StRun;
            pc_q          <= RESET_PC;
            d_pc_q        <= 32'd0;
            d_pc_four_q   <= 32'd0;
            d_instr_q     <= NOP_INSTR;
            d_valid_q     <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            d_pc_q        <= d_pc_d;
            d_pc_four_q   <= d_pc_four_d;
            d_instr_q     <= d_instr_d;
            d_valid_q     <= d_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign InstrAddr  = pc_q;
    assign D_PC       = d_pc_q;
    assign D_PCFour   = d_pc_four_q;
    assign D_Instr    = d_instr_q;
    assign D_Valid    = d_valid_q;
    assign Halted     = (state_q == StHalted);
    assign FetchCount = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage. Instruction memory returns word = address.
// Each directed step drives inputs for one edge and pushes the hand-computed
// post-edge state; a monitor pops and compares on every falling edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic [31:0] BranchTarget = 32'd0;
    logic        HaltD = 1'b0;
    logic [31:0] InstrAddr;
    logic [31:0] InstrData;
    logic [31:0] D_PC;
    logic [31:0] D_PCFour;
    logic [31:0] D_Instr;
    logic        D_Valid;
    logic        Halted;
    logic [31:0] FetchCount;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          step;
        logic [31:0] addr;
        logic [31:0] dpc;
        logic [31:0] dpc4;
        logic [31:0] instr;
        logic        valid;
        logic        halted;
        logic [31:0] count;
    } exp_t;

    exp_t exp_q[$];
    int   step_no = 0;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Stall       (Stall),
        .Flush       (Flush),
        .BranchTarget(BranchTarget),
        .HaltD       (HaltD),
        .InstrAddr   (InstrAddr),
        .InstrData   (InstrData),
        .D_PC        (D_PC),
        .D_PCFour    (D_PCFour),
        .D_Instr     (D_Instr),
        .D_Valid     (D_Valid),
        .Halted      (Halted),
        .FetchCount  (FetchCount)
    );

    assign InstrData = InstrAddr;

    always #5 clk = ~clk;

    task automatic check(input int step, input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL step %0d %s: got %h, expected %h", step, name, act, req);
        end
    endtask

    // Monitor: DUT state after each edge is compared on the following falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.step, "InstrAddr",  InstrAddr,          e.addr);
                check(e.step, "D_PC",       D_PC,               e.dpc);
                check(e.step, "D_PCFour",   D_PCFour,           e.dpc4);
                check(e.step, "D_Instr",    D_Instr,            e.instr);
                check(e.step, "D_Valid",    {31'd0, D_Valid},   {31'd0, e.valid});
                check(e.step, "Halted",     {31'd0, Halted},    {31'd0, e.halted});
                check(e.step, "FetchCount", FetchCount,         e.count);
            end
        end
    end

    task automatic step(input logic rst, input logic stall, input logic flush,
                        input logic [31:0] tgt, input logic haltd,
                        input logic [31:0] addr, input logic [31:0] dpc,
                        input logic [31:0] dpc4, input logic [31:0] instr,
                        input logic valid, input logic halted, input logic [31:0] count);
        exp_t e;
        reset        = rst;
        Stall        = stall;
        Flush        = flush;
        BranchTarget = tgt;
        HaltD        = haltd;
        @(posedge clk);
        #1;
        step_no++;
        e.step   = step_no;
        e.addr   = addr;
        e.dpc    = dpc;
        e.dpc4   = dpc4;
        e.instr  = instr;
        e.valid  = valid;
        e.halted = halted;
        e.count  = count;
        exp_q.push_back(e);
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;

    initial begin
        //   rst stl fl  target        hlt  addr           dpc            dpc4           instr          v  h  cnt
        // Reset, then free-run.
        step(1, 0, 0, 32'h0,         0, 32'h0,         32'h0,         32'h0,         NOP,           0, 0, 0);
        step(0, 0, 0, 32'h0,         0, 32'h4,         32'h0,         32'h4,         32'h0,         1, 0, 1);
        step(0, 0, 0, 32'h0,         0, 32'h8,         32'h4,         32'h8,         32'h4,         1, 0, 2);
        step(0, 0, 0, 32'h0,         0, 32'hC,         32'h8,         32'hC,         32'h8,         1, 0, 3);
        // Two-cycle stall holding PC 8 in IF/ID.
        step(0, 1, 0, 32'h0,         0, 32'hC,         32'h8,         32'hC,         32'h8,         1, 0, 3);
        step(0, 1, 0, 32'h0,         0, 32'hC,         32'h8,         32'hC,         32'h8,         1, 0, 3);
        step(0, 0, 0, 32'h0,         0, 32'h10,        32'hC,         32'h10,        32'hC,         1, 0, 4);
        // Flush overrides Stall; target low bits dropped.
        step(0, 1, 1, 32'h103,       0, 32'h100,       32'hC,         32'h10,        NOP,           0, 0, 4);
        step(0, 0, 0, 32'h0,         0, 32'h104,       32'h100,       32'h104,       32'h100,       1, 0, 5);
        // HaltD with Flush: no halt, redirect wins.
        step(0, 0, 1, 32'h200,       1, 32'h200,       32'h100,       32'h104,       NOP,           0, 0, 5);
        // HaltD over a bubble is not a halt.
        step(0, 0, 0, 32'h0,         1, 32'h204,       32'h200,       32'h204,       32'h200,       1, 0, 6);
        // Valid HALT: halted, PC frozen.
        step(0, 0, 0, 32'h0,         1, 32'h204,       32'h200,       32'h204,       NOP,           0, 1, 6);
        step(0, 1, 1, 32'h300,       0, 32'h204,       32'h200,       32'h204,       NOP,           0, 1, 6);
        step(0, 0, 1, 32'h400,       0, 32'h204,       32'h200,       32'h204,       NOP,           0, 1, 6);
        step(0, 0, 0, 32'h0,         0, 32'h204,       32'h200,       32'h204,       NOP,           0, 1, 6);
        // Reset out of HALTED.
        step(1, 0, 0, 32'h0,         0, 32'h0,         32'h0,         32'h0,         NOP,           0, 0, 0);
        step(0, 0, 0, 32'h0,         0, 32'h4,         32'h0,         32'h4,         32'h0,         1, 0, 1);
        // PC wrap.
        step(0, 0, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 32'h0,         32'h4,         NOP,           0, 0, 1);
        step(0, 0, 0, 32'h0,         0, 32'h0,         32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFC, 1, 0, 2);
        step(0, 0, 0, 32'h0,         0, 32'h4,         32'h0,         32'h4,         32'h0,         1, 0, 3);
        // Reset mid-stall.
        step(1, 1, 0, 32'h0,         0, 32'h0,         32'h0,         32'h0,         NOP,           0, 0, 0);
        step(0, 0, 0, 32'h0,         0, 32'h4,         32'h0,         32'h4,         32'h0,         1, 0, 1);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
